// File: rtl/nrisc_irq_ctrl_pkg.sv
// Shared constants and config encodings for the nRISC interrupt controller.
package nrisc_irq_ctrl_pkg;

  localparam int         STACK_TAM      = 8;
  localparam int         N_IRQ_DEF      = 8;
  localparam logic [7:0] VEC_BASE_DEF   = 8'h10;
  localparam int         VEC_STRIDE_DEF = 4;
  // One PC stack slot stays reserved for the interrupted main thread.
  localparam int         MAX_NEST_DEF   = STACK_TAM - 1;

  typedef enum logic [1:0] {
    CFG_MASK = 2'd0,
    CFG_EN   = 2'd1,
    CFG_CLR  = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;

endpackage

// File: rtl/nrisc_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module nrisc_prio_enc
  import nrisc_irq_ctrl_pkg::*;
#(
  parameter int N     = N_IRQ_DEF,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nrisc_irq_ctrl.sv
// Interrupt arbiter: edge latching, mask/enable, fixed-priority pre-emptive
// injection into the PC controller with bounded nesting.
module nrisc_irq_ctrl
  import nrisc_irq_ctrl_pkg::*;
#(
  parameter int         N_IRQ      = N_IRQ_DEF,
  parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int         VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int         MAX_NEST   = MAX_NEST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] IRQ_in,
  input  logic             CFG_we,
  input  logic [1:0]       CFG_sel,
  input  logic [N_IRQ-1:0] CFG_data,
  input  logic [1:0]       CORE_PC_ctrl,
  input  logic             CORE_IRET,
  output logic             INTERRUPT_flag,
  output logic [7:0]       INTERRUPT_ch,
  output logic [N_IRQ-1:0] IRQ_pending,
  output logic [N_IRQ-1:0] IRQ_inservice
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int CNT_W = $clog2(N_IRQ + 1);

  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] inservice;
  logic [N_IRQ-1:0] mask;
  logic             enable;
  logic             flag;
  logic [7:0]       ch;

  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] eligible;
  logic [IDX_W-1:0] cand_idx;
  logic             cand_any;
  logic [IDX_W-1:0] isr_idx;
  logic             isr_any;
  logic [N_IRQ-1:0] cand_oh;
  logic [N_IRQ-1:0] isr_oh;
  logic [CNT_W-1:0] nest_cnt;
  logic             cand_ok;
  logic             nest_ok;
  logic             inject;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] pending_nxt;
  logic [N_IRQ-1:0] inservice_nxt;

  function automatic logic [7:0] vec_addr(input logic [IDX_W-1:0] idx);
    logic [31:0] a;
    a = 32'(VEC_BASE) + 32'(idx) * 32'(VEC_STRIDE);
    return a[7:0];
  endfunction

  function automatic logic [CNT_W-1:0] count_ones(input logic [N_IRQ-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_IRQ; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign edge_det = IRQ_in & ~irq_prev;
  assign eligible = pending & mask;

  nrisc_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_cand_enc (
    .req   (eligible),
    .idx   (cand_idx),
    .valid (cand_any)
  );

  // The lowest in-service index is both the pre-emption threshold and the IRET target.
  nrisc_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_isr_enc (
    .req   (inservice),
    .idx   (isr_idx),
    .valid (isr_any)
  );

  assign cand_oh  = N_IRQ'(1) << cand_idx;
  assign isr_oh   = N_IRQ'(1) << isr_idx;
  assign nest_cnt = count_ones(inservice);
  assign cand_ok  = cand_any && (!isr_any || (cand_idx < isr_idx));
  assign nest_ok  = int'(nest_cnt) < MAX_NEST;
  assign inject   = enable && cand_ok && (CORE_PC_ctrl == 2'b00) && !CORE_IRET
                    && !flag && nest_ok;

  always_comb begin
    clr = '0;
    if (CFG_we && (CFG_sel == CFG_CLR)) clr = CFG_data;
    if (inject) clr = clr | cand_oh;
    // A same-cycle edge always survives a clear.
    pending_nxt   = (pending & ~clr) | edge_det;
    inservice_nxt = inservice;
    if (inject) inservice_nxt = inservice | cand_oh;
    else if (CORE_IRET && isr_any) inservice_nxt = inservice & ~isr_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev  <= '0;
      pending   <= '0;
      inservice <= '0;
      mask      <= '0;
      enable    <= 1'b0;
      flag      <= 1'b0;
      ch        <= '0;
    end else begin
      irq_prev  <= IRQ_in;
      pending   <= pending_nxt;
      inservice <= inservice_nxt;
      if (CFG_we && (CFG_sel == CFG_MASK)) mask <= CFG_data;
      if (CFG_we && (CFG_sel == CFG_EN)) enable <= CFG_data[0];
      flag <= inject;
      if (inject) ch <= vec_addr(cand_idx);
    end
  end

  assign INTERRUPT_flag = flag;
  assign INTERRUPT_ch   = ch;
  assign IRQ_pending    = pending;
  assign IRQ_inservice  = inservice;

endmodule

// File: tb/tb_nrisc_irq_ctrl.sv
// Scoreboard bench for nrisc_irq_ctrl: expected vectors queued at stimulus time.
module tb_nrisc_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] IRQ_in;
  logic       CFG_we;
  logic [1:0] CFG_sel;
  logic [7:0] CFG_data;
  logic [1:0] CORE_PC_ctrl;
  logic       CORE_IRET;
  logic       INTERRUPT_flag;
  logic [7:0] INTERRUPT_ch;
  logic [7:0] IRQ_pending;
  logic [7:0] IRQ_inservice;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic       prev_flag = 1'b0;
  int         lat;

  nrisc_irq_ctrl #(.MAX_NEST(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .IRQ_in         (IRQ_in),
    .CFG_we         (CFG_we),
    .CFG_sel        (CFG_sel),
    .CFG_data       (CFG_data),
    .CORE_PC_ctrl   (CORE_PC_ctrl),
    .CORE_IRET      (CORE_IRET),
    .INTERRUPT_flag (INTERRUPT_flag),
    .INTERRUPT_ch   (INTERRUPT_ch),
    .IRQ_pending    (IRQ_pending),
    .IRQ_inservice  (IRQ_inservice)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every flag pulse must match the oldest queued vector and never be back-to-back.
  always @(negedge clk) begin
    if (INTERRUPT_flag) begin
      check("flag_width", int'(prev_flag), 0);
      if (exp_q.size() == 0) check("unexpected_flag", int'(INTERRUPT_ch), -1);
      else check("vector", int'(INTERRUPT_ch), int'(exp_q.pop_front()));
    end
    prev_flag = INTERRUPT_flag;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply one cycle of stimulus, then count edges until the flag rises (-1 if never).
  task automatic drive(input logic [7:0] irq, input int ctrl_cyc, input logic iret,
                       input logic we, input logic [1:0] sel, input logic [7:0] data,
                       output int l);
    IRQ_in       = irq;
    CORE_PC_ctrl = (ctrl_cyc > 0) ? 2'b01 : 2'b00;
    CORE_IRET    = iret;
    CFG_we       = we;
    CFG_sel      = sel;
    CFG_data     = data;
    l = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      IRQ_in    = '0;
      CORE_IRET = 1'b0;
      CFG_we    = 1'b0;
      if (c >= ctrl_cyc) CORE_PC_ctrl = 2'b00;
      if (INTERRUPT_flag) begin
        l = c;
        break;
      end
    end
  endtask

  task automatic irq(input logic [7:0] m, output int l);
    drive(m, 0, 1'b0, 1'b0, 2'd0, 8'h00, l);
  endtask

  task automatic iret(output int l);
    drive(8'h00, 0, 1'b1, 1'b0, 2'd0, 8'h00, l);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] data, output int l);
    drive(8'h00, 0, 1'b0, 1'b1, sel, data, l);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; IRQ_in = '0; CFG_we = 1'b0; CFG_sel = '0; CFG_data = '0;
    CORE_PC_ctrl = '0; CORE_IRET = 1'b0;
    step(2);
    check("rst_flag", int'(INTERRUPT_flag), 0);
    check("rst_ch", int'(INTERRUPT_ch), 0);
    check("rst_pend", int'(IRQ_pending), 0);
    check("rst_isr", int'(IRQ_inservice), 0);
    rst = 1'b0;
    step(1);

    // Single request, basic latency
    cfg(2'd0, 8'hFF, lat);
    cfg(2'd1, 8'h01, lat);
    exp_q.push_back(8'h1C);
    irq(8'h08, lat);
    check("t1_lat", lat, 2);
    check("t1_isr", int'(IRQ_inservice), 8'h08);
    check("t1_pend", int'(IRQ_pending), 0);
    step(1);
    check("t1_pulse_len", int'(INTERRUPT_flag), 0);
    check("t1_ch_hold", int'(INTERRUPT_ch), 8'h1C);
    iret(lat);
    check("t1_iret_lat", lat, -1);
    check("t1_iret_isr", int'(IRQ_inservice), 0);

    // Simultaneous requests: priority, then held until IRET
    exp_q.push_back(8'h14);
    irq(8'h22, lat);
    check("t2_lat", lat, 2);
    check("t2_isr", int'(IRQ_inservice), 8'h02);
    check("t2_pend", int'(IRQ_pending), 8'h20);
    step(6);
    check("t2_pend_held", int'(IRQ_pending), 8'h20);
    exp_q.push_back(8'h24);
    iret(lat);
    check("t2_iret_lat", lat, 2);
    check("t2_isr5", int'(IRQ_inservice), 8'h20);
    iret(lat);
    check("t2_isr_clr", int'(IRQ_inservice), 0);

    // Pre-emptive nesting; lower priority waits
    exp_q.push_back(8'h20);
    irq(8'h10, lat);
    check("t3_lat4", lat, 2);
    exp_q.push_back(8'h18);
    irq(8'h04, lat);
    check("t3_lat2", lat, 2);
    check("t3_isr", int'(IRQ_inservice), 8'h14);
    irq(8'h40, lat);
    check("t3_ch6_blocked", lat, -1);
    check("t3_pend6", int'(IRQ_pending), 8'h40);
    iret(lat);
    check("t3_iret1_lat", lat, -1);
    check("t3_iret1_isr", int'(IRQ_inservice), 8'h10);
    exp_q.push_back(8'h28);
    iret(lat);
    check("t3_iret2_lat", lat, 2);
    check("t3_isr6", int'(IRQ_inservice), 8'h40);
    iret(lat);
    check("t3_isr_clr", int'(IRQ_inservice), 0);

    // Branch in flight delays injection
    exp_q.push_back(8'h10);
    drive(8'h01, 3, 1'b0, 1'b0, 2'd0, 8'h00, lat);
    check("t4_lat", lat, 4);
    iret(lat);
    check("t4_isr_clr", int'(IRQ_inservice), 0);

    // Masking, late unmask, clear vs same-cycle edge
    cfg(2'd0, 8'h00, lat);
    irq(8'h04, lat);
    check("t5_masked", lat, -1);
    check("t5_pend", int'(IRQ_pending), 8'h04);
    exp_q.push_back(8'h18);
    cfg(2'd0, 8'h04, lat);
    check("t5_unmask_lat", lat, 2);
    check("t5_pend_clr", int'(IRQ_pending), 0);
    iret(lat);
    cfg(2'd0, 8'h00, lat);
    irq(8'h04, lat);
    drive(8'h04, 0, 1'b0, 1'b1, 2'd2, 8'h04, lat);
    check("t5_edge_wins", int'(IRQ_pending), 8'h04);
    cfg(2'd2, 8'h04, lat);
    check("t5_w1c", int'(IRQ_pending), 0);

    // Nest limit, then reset mid-service
    cfg(2'd0, 8'hFF, lat);
    exp_q.push_back(8'h20);
    irq(8'h10, lat);
    check("t6_lat4", lat, 2);
    exp_q.push_back(8'h18);
    irq(8'h04, lat);
    check("t6_lat2", lat, 2);
    irq(8'h01, lat);
    check("t6_full", lat, -1);
    check("t6_pend0", int'(IRQ_pending), 8'h01);
    exp_q.push_back(8'h10);
    iret(lat);
    check("t6_iret_lat", lat, 2);
    check("t6_isr", int'(IRQ_inservice), 8'h11);
    IRQ_in = 8'h80;
    rst = 1'b1;
    step(1);
    check("t6_rst_flag", int'(INTERRUPT_flag), 0);
    check("t6_rst_ch", int'(INTERRUPT_ch), 0);
    check("t6_rst_pend", int'(IRQ_pending), 0);
    check("t6_rst_isr", int'(IRQ_inservice), 0);
    rst = 1'b0;
    step(1);
    check("t6_held_edge", int'(IRQ_pending), 8'h80);
    IRQ_in = 8'h00;
    irq(8'h02, lat);
    check("t6_mask_reset", lat, -1);
    check("t6_pend_after", int'(IRQ_pending), 8'h82);

    check("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
